sync_dp_mem: RTL and testbench



---
 rtl/sync_mem_pkg.sv | 10 +
 rtl/mem_clear_ctrl.sv | 50 +++++
 rtl/sync_dp_mem.sv | 135 +++++++++++++
 tb/tb_sync_dp_mem.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_mem_pkg.sv
// Shared types and constants for the synchronous dual-port memory.
// No logic; imported by the controller and the memory top.
package sync_mem_pkg;

  typedef enum logic {CLEAR, READY} mem_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/mem_clear_ctrl.sv
// Post-reset array-clear sequencer: sweeps every address once, then stays READY.
// Latency: DEPTH edges of busy after reset release; requests are refused while busy.
import sync_mem_pkg::*;

module mem_clear_ctrl #(
  parameter int ADDR_WIDTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clearWrite,
  output logic [ADDR_WIDTH-1:0] clearAddress
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  mem_state_t            state;
  mem_state_t            nextState;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic [ADDR_WIDTH-1:0] nextClrAddr;

  // Reset mid-sweep restarts from address 0, so no partial clear can survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clrAddr <= '0;
    end else begin
      state   <= nextState;
      clrAddr <= nextClrAddr;
    end
  end

  always_comb begin
    nextState   = state;
    nextClrAddr = clrAddr;
    if (state == CLEAR) begin
      if (clrAddr == LastAddr) begin
        nextState = READY;
      end else begin
        nextClrAddr = clrAddr + 1'b1;
      end
    end
  end

  assign busy         = (state == CLEAR);
  assign clearWrite   = (state == CLEAR);
  assign clearAddress = clrAddr;

endmodule

// File: rtl/sync_dp_mem.sv
// Simple dual-port RAM, byte-lane writes, selectable read latency and read-during-write data.
// Latency: READ_LATENCY edges from read request to readData/readValid; busy refuses all requests.
import sync_mem_pkg::*;

module sync_dp_mem #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : gBadWidth
    $error("sync_dp_mem: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
    $error("sync_dp_mem: READ_LATENCY must be 1 or 2");
  end

  logic                  clearWrite;
  logic [ADDR_WIDTH-1:0] clearAddress;

  mem_clear_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) uClearCtrl (
    .clk         (clk),
    .reset       (reset),
    .busy        (busy),
    .clearWrite  (clearWrite),
    .clearAddress(clearAddress)
  );

  logic acceptWrite;
  logic acceptRead;

  assign acceptWrite = ~busy & writeEnable;
  assign acceptRead  = ~busy & readEnable;

  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memWrAddr;
  logic [DATA_WIDTH-1:0] memWrData;
  logic [LANES-1:0]      memWrLanes;

  // The clear sweep borrows the single write port.
  always_comb begin
    memWrite   = acceptWrite;
    memWrAddr  = writeAddress;
    memWrData  = writeData;
    memWrLanes = byteEnable;
    if (clearWrite) begin
      memWrite   = 1'b1;
      memWrAddr  = clearAddress;
      memWrData  = '0;
      memWrLanes = '1;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (memWrite && memWrLanes[i]) begin
        mem[memWrAddr][8*i +: 8] <= memWrData[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] storedWord;
  logic [DATA_WIDTH-1:0] readWord;

  assign storedWord = mem[readAddress];

  if (RDW_MODE == RDW_OLD) begin : gOldData
    assign readWord = storedWord;
  end else begin : gNewData
    always_comb begin
      readWord = storedWord;
      if (acceptWrite && (writeAddress == readAddress)) begin
        for (int i = 0; i < LANES; i++) begin
          if (byteEnable[i]) begin
            readWord[8*i +: 8] = writeData[8*i +: 8];
          end
        end
      end
    end
  end

  // Each stage only reloads on a valid slot, so idle cycles hold the last result.
  for (genvar s = 0; s < READ_LATENCY; s++) begin : gStage
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  validIn;

    if (s == 0) begin : gHead
      assign dataIn  = readWord;
      assign validIn = acceptRead;
    end else begin : gTail
      assign dataIn  = gStage[s-1].data;
      assign validIn = gStage[s-1].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data  <= '0;
        valid <= 1'b0;
      end else begin
        valid <= validIn;
        if (validIn) begin
          data <= dataIn;
        end
      end
    end
  end

  assign readData  = gStage[READ_LATENCY-1].data;
  assign readValid = gStage[READ_LATENCY-1].valid;

endmodule

// File: tb/tb_sync_dp_mem.sv
// Directed bench for sync_dp_mem across three parameter sets sharing one clock and reset.
module tb_sync_dp_mem;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // DUT a: defaults (8-bit, latency 1, old data, clear on reset)
  logic       aWe = 0, aRe = 0;
  logic [3:0] aWa = 0, aRa = 0;
  logic [7:0] aWd = 0;
  logic [0:0] aBe = 0;
  logic [7:0] aData;
  logic       aValid, aBusy;

  // DUT b: 8-bit, latency 2, new data, clear on reset
  logic       bWe = 0, bRe = 0;
  logic [3:0] bWa = 0, bRa = 0;
  logic [7:0] bWd = 0;
  logic [0:0] bBe = 0;
  logic [7:0] bData;
  logic       bValid, bBusy;

  // DUT c: 32-bit, latency 1, old data, no clear
  logic        cWe = 0, cRe = 0;
  logic [3:0]  cWa = 0, cRa = 0;
  logic [31:0] cWd = 0;
  logic [3:0]  cBe = 0;
  logic [31:0] cData;
  logic        cValid, cBusy;

  sync_dp_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dutA (
    .clk(clk), .reset(reset), .writeEnable(aWe), .writeAddress(aWa), .writeData(aWd),
    .byteEnable(aBe), .readEnable(aRe), .readAddress(aRa), .readData(aData),
    .readValid(aValid), .busy(aBusy));

  sync_dp_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dutB (
    .clk(clk), .reset(reset), .writeEnable(bWe), .writeAddress(bWa), .writeData(bWd),
    .byteEnable(bBe), .readEnable(bRe), .readAddress(bRa), .readData(bData),
    .readValid(bValid), .busy(bBusy));

  sync_dp_mem #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dutC (
    .clk(clk), .reset(reset), .writeEnable(cWe), .writeAddress(cWa), .writeData(cWd),
    .byteEnable(cBe), .readEnable(cRe), .readAddress(cRa), .readData(cData),
    .readValid(cValid), .busy(cBusy));

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       be;
    logic       re;
    logic [3:0] ra;
    logic       expValid;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts busy cycles of dutA across a fresh clear, with requests held high throughout.
  task automatic clearSweep(input string tag);
    int busyCount = 0;
    aWe = 1; aWa = 4'd0; aWd = 8'hFF; aBe = 1'b1; aRe = 1; aRa = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (aBusy) busyCount++;
      check($sformatf("%s_valid_while_busy_%0d", tag, k), {31'd0, aValid}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_busy_count"}, busyCount, 32'd16);
    check({tag, "_busy_fallen"}, {31'd0, aBusy}, 32'd0);
    check({tag, "_last_busy_req_dropped"}, {31'd0, aValid}, 32'd0);
    aWe = 0; aRe = 0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd5, 8'h01, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 4'd5, 8'hFF, 1'b1, 1'b1, 4'd5, 1'b1, 8'h01};
    vecs[2]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5, 1'b1, 8'hFF};
    vecs[3]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'hFF};
    vecs[4]  = '{1'b1, 4'd7, 8'hA5, 1'b0, 1'b1, 4'd7, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd7, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 4'd9, 8'h3C, 1'b1, 1'b1, 4'd5, 1'b1, 8'hFF};
    vecs[7]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd9, 1'b1, 8'h3C};
    vecs[8]  = '{1'b1, 4'd9, 8'hC3, 1'b1, 1'b0, 4'd0, 1'b0, 8'h3C};
    vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd15, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd9, 1'b1, 8'hC3};

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_a_data", {24'd0, aData}, 32'd0);
    check("rst_a_valid", {31'd0, aValid}, 32'd0);
    check("rst_a_busy", {31'd0, aBusy}, 32'd1);
    check("rst_b_busy", {31'd0, bBusy}, 32'd1);
    check("rst_c_busy", {31'd0, cBusy}, 32'd0);
    check("rst_c_data", cData, 32'd0);

    // Initial clear, with ignored requests on dutA
    reset = 0;
    clearSweep("clr");
    check("clr_b_busy_fallen", {31'd0, bBusy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      aRe = 1; aRa = 4'(i);
      @(negedge clk);
      check($sformatf("clr_read_data_%0d", i), {24'd0, aData}, 32'd0);
      check($sformatf("clr_read_valid_%0d", i), {31'd0, aValid}, 32'd1);
    end
    aRe = 0;

    // Table-driven vectors on dutA
    for (int i = 0; i < 11; i++) begin
      aWe = vecs[i].we; aWa = vecs[i].wa; aWd = vecs[i].wd; aBe = vecs[i].be;
      aRe = vecs[i].re; aRa = vecs[i].ra;
      @(negedge clk);
      check($sformatf("vec%0d_data", i), {24'd0, aData}, {24'd0, vecs[i].expData});
      check($sformatf("vec%0d_valid", i), {31'd0, aValid}, {31'd0, vecs[i].expValid});
    end
    aWe = 0; aRe = 0;

    // dutB: fill, new-data read-during-write, latency 2
    bBe = 1'b1; bWe = 1;
    bWa = 4'd1; bWd = 8'h11; @(negedge clk);
    bWa = 4'd2; bWd = 8'h22; @(negedge clk);
    bWa = 4'd3; bWd = 8'h33; @(negedge clk);
    bWa = 4'd5; bWd = 8'h01; @(negedge clk);
    bWa = 4'd5; bWd = 8'hFF; bRe = 1; bRa = 4'd5;
    @(negedge clk);
    bWe = 0; bRe = 0;
    check("b_rdw_not_yet_valid", {31'd0, bValid}, 32'd0);
    @(negedge clk);
    check("b_rdw_new_data", {24'd0, bData}, 32'h000000FF);
    check("b_rdw_valid", {31'd0, bValid}, 32'd1);
    bRe = 1; bRa = 4'd5;
    @(negedge clk);
    bRe = 0;
    @(negedge clk);
    check("b_after_rdw_data", {24'd0, bData}, 32'h000000FF);
    check("b_after_rdw_valid", {31'd0, bValid}, 32'd1);
    bRe = 1; bRa = 4'd1;
    @(negedge clk);
    check("b_lat_n_valid", {31'd0, bValid}, 32'd0);
    bRa = 4'd2;
    @(negedge clk);
    check("b_lat_n1_data", {24'd0, bData}, 32'h00000011);
    check("b_lat_n1_valid", {31'd0, bValid}, 32'd1);
    bRa = 4'd3;
    @(negedge clk);
    check("b_lat_n2_data", {24'd0, bData}, 32'h00000022);
    check("b_lat_n2_valid", {31'd0, bValid}, 32'd1);
    bRe = 0;
    @(negedge clk);
    check("b_lat_n3_data", {24'd0, bData}, 32'h00000033);
    check("b_lat_n3_valid", {31'd0, bValid}, 32'd1);
    @(negedge clk);
    check("b_lat_hold_data", {24'd0, bData}, 32'h00000033);
    check("b_lat_hold_valid", {31'd0, bValid}, 32'd0);

    // dutC: byte-lane writes and old-data read-during-write
    cWe = 1; cWa = 4'd3; cWd = 32'hAABBCCDD; cBe = 4'b1111;
    @(negedge clk);
    cWd = 32'h11223344; cBe = 4'b0101;
    @(negedge clk);
    cWe = 0; cRe = 1; cRa = 4'd3;
    @(negedge clk);
    check("c_byte_lanes", cData, 32'hAA22CC44);
    check("c_byte_lanes_valid", {31'd0, cValid}, 32'd1);
    cWe = 1; cWd = 32'h00000000; cBe = 4'b1000;
    @(negedge clk);
    check("c_rdw_old", cData, 32'hAA22CC44);
    cWe = 0;
    @(negedge clk);
    check("c_top_lane_cleared", cData, 32'h0022CC44);
    cRe = 0;

    // Reset mid-clear on dutA; dutC write at first edge after reset
    reset = 1;
    @(negedge clk);
    check("rst2_a_busy", {31'd0, aBusy}, 32'd1);
    check("rst2_a_data", {24'd0, aData}, 32'd0);
    check("rst2_c_busy", {31'd0, cBusy}, 32'd0);
    check("rst2_c_data", cData, 32'd0);
    reset = 0;
    cWe = 1; cWa = 4'd6; cWd = 32'h12345678; cBe = 4'b1111;
    @(negedge clk);
    cWe = 0; cRe = 1; cRa = 4'd6;
    @(negedge clk);
    check("c_first_edge_write", cData, 32'h12345678);
    check("c_first_edge_valid", {31'd0, cValid}, 32'd1);
    cRa = 4'd3;
    @(negedge clk);
    check("c_survives_reset", cData, 32'h0022CC44);
    cRe = 0;
    repeat (4) @(negedge clk);
    check("mid_clear_still_busy", {31'd0, aBusy}, 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    clearSweep("reclr");
    aRe = 1; aRa = 4'd15;
    @(negedge clk);
    check("reclr_addr15", {24'd0, aData}, 32'd0);
    check("reclr_addr15_valid", {31'd0, aValid}, 32'd1);
    aRa = 4'd9;
    @(negedge clk);
    check("reclr_addr9", {24'd0, aData}, 32'd0);
    aRe = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
